// File: rtl/ooo_fetch_unit_pkg.sv
// Shared types and defaults for the fetch front-end: packet layout, FSM encoding, queue depth.
package ooo_fetch_unit_pkg;

  localparam int          FETCH_QDEPTH   = 8;
  localparam logic [31:0] FETCH_RESET_PC = 32'h1eceb000;
  localparam logic [3:0]  IMEM_RMASK_RD  = 4'hF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DISCARD
  } fetch_state_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ooo_fetch_queue.sv
// In-order circular instruction queue; head is combinational, all-ones when empty.
// Flush has priority over a same-cycle push/pop; pop on empty is ignored.
module ooo_fetch_queue
  import ooo_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_QDEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  fetch_pkt_t               i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_pkt_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_pkt_t      r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            w_empty;
  logic            w_full;
  logic            w_do_pop;
  logic            w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + AW'(1);
      if (w_do_pop)  r_head <= r_head + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !i_flush) r_mem[r_tail] <= i_push_dat;
  end

  assign o_head  = w_empty ? '1 : r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/ooo_fetch_unit.sv
// Fetch stage: owns the fetch PC, one outstanding I-mem read, redirects on predict/mispredict.
// Request issues the cycle it is asserted; a slot is reserved at issue so the queue never overflows.
module ooo_fetch_unit
  import ooo_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          QDEPTH   = FETCH_QDEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output fetch_pkt_t  fifo_out,
  output logic        fetch_en,
  input  logic        fifo_pop,
  input  logic        predict_taken,
  input  logic [31:0] pc_target,
  input  logic        mispredict,
  input  logic [31:0] actual_target
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   w_target;
  logic          w_redirect;
  logic          w_issue;
  logic          w_push;
  logic          w_full;
  logic [CW-1:0] w_count;
  fetch_pkt_t    w_push_dat;

  // predict_taken only counts once the predictor has actually consumed the branch
  assign w_redirect = mispredict | (predict_taken & fifo_pop);
  assign w_target   = mispredict ? actual_target : pc_target;
  assign w_full     = (w_count == FULL_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      REQ: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (!w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = imem_resp ? REQ : DISCARD;
        end else if (imem_resp) begin
          w_push      = 1'b1;
          w_pc_nxt    = seq_pc(r_pc);
          w_state_nxt = REQ;
        end
      end
      DISCARD: begin
        if (w_redirect) w_pc_nxt = w_target;
        if (imem_resp)  w_state_nxt = REQ;
      end
      default: w_state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign imem_addr       = {r_pc[31:2], 2'b00};
  assign imem_rmask      = w_issue ? IMEM_RMASK_RD : 4'h0;
  assign w_push_dat.pc   = r_pc;
  assign w_push_dat.inst = imem_rdata;
  assign fetch_en        = (w_count != '0);

  ooo_fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (fifo_pop),
    .i_flush    (w_redirect),
    .o_head     (fifo_out),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_ooo_fetch_unit.sv
// Bench for ooo_fetch_unit: directed table, hand sequences and a randomized run against a queue-based model.
module tb_ooo_fetch_unit;
  import ooo_fetch_unit_pkg::*;

  localparam logic [31:0] RPC = 32'h1eceb000;
  localparam int          QD  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  fetch_pkt_t  fifo_out;
  logic        fetch_en;
  logic        fifo_pop;
  logic        predict_taken;
  logic [31:0] pc_target;
  logic        mispredict;
  logic [31:0] actual_target;

  always #5 clk = ~clk;

  ooo_fetch_unit #(
    .RESET_PC (RPC),
    .QDEPTH   (QD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rmask    (imem_rmask),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .fifo_out      (fifo_out),
    .fetch_en      (fetch_en),
    .fifo_pop      (fifo_pop),
    .predict_taken (predict_taken),
    .pc_target     (pc_target),
    .mispredict    (mispredict),
    .actual_target (actual_target)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9e3779b9;
  endfunction

  // memory: answers each request after mem_lat cycles (or a random 1..3)
  bit          mem_pend = 0;
  int          mem_wait = 0;
  logic [31:0] mem_req_addr = '0;
  int          mem_lat  = 1;
  bit          mem_rand = 0;

  // reference model: expected queue contents, fetch pc, outstanding-read status
  fetch_pkt_t  mq[$];
  logic [31:0] m_pc = RPC;
  int          m_out = 0;   // 0 none, 1 live read, 2 read whose data must be dropped

  function automatic bit m_redirect();
    return mispredict || (predict_taken && fifo_pop);
  endfunction

  function automatic bit m_issue();
    return (m_out == 0) && (mq.size() < QD) && !m_redirect();
  endfunction

  task automatic check_model();
    fetch_pkt_t e;
    if (rst) return;
    chk("m_rmask", imem_rmask, m_issue() ? 4'hF : 4'h0);
    if (m_issue()) chk("m_addr", imem_addr, {m_pc[31:2], 2'b00});
    chk("m_fetch_en", fetch_en, mq.size() > 0);
    if (mq.size() > 0) e = mq[0];
    else e = '1;
    chk("m_fifo_out", fifo_out, e);
  endtask

  task automatic advance();
    logic [31:0] tgt;
    bit          redir;
    bit          iss;
    fetch_pkt_t  p;
    tgt   = mispredict ? actual_target : pc_target;
    redir = m_redirect();
    iss   = m_issue();
    if (rst) begin
      mq.delete();
      m_pc  = RPC;
      m_out = 0;
    end else begin
      if (redir) mq.delete();
      else begin
        if (fifo_pop && mq.size() > 0) void'(mq.pop_front());
        if (imem_resp && m_out == 1) begin
          p.pc   = m_pc;
          p.inst = imem_rdata;
          mq.push_back(p);
        end
      end
      if (redir) m_pc = tgt;
      else if (imem_resp && m_out == 1) m_pc = m_pc + 32'd4;
      if (imem_resp) m_out = 0;
      else if (redir && m_out == 1) m_out = 2;
      if (iss) m_out = 1;
    end
    if (rst) mem_pend = 0;
    else if (imem_rmask == 4'hF) begin
      mem_pend     = 1;
      mem_req_addr = imem_addr;
      mem_wait     = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
    end
    @(posedge clk);
    #1;
    imem_resp  = 1'b0;
    imem_rdata = $urandom();
    if (mem_pend) begin
      mem_wait--;
      if (mem_wait <= 0) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(mem_req_addr);
        mem_pend   = 0;
      end
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    check_model();
    advance();
  endtask

  task automatic set_in(input bit pop, input bit pt, input logic [31:0] ptt,
                        input bit mp, input logic [31:0] mpt);
    fifo_pop      = pop;
    predict_taken = pt;
    pc_target     = ptt;
    mispredict    = mp;
    actual_target = mpt;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    set_in(0, 0, '0, 0, '0);
    repeat (n) begin
      settle();
      tick();
    end
    rst = 1'b0;
  endtask

  typedef struct {
    bit          pop;
    bit          pt;
    logic [31:0] ptt;
    bit          mp;
    logic [31:0] mpt;
    logic [3:0]  e_rmask;
    logic [31:0] e_addr;
    bit          e_fe;
    logic [31:0] e_hpc;
  } vec_t;

  function automatic vec_t mk(input bit pop, input bit pt, input logic [31:0] ptt,
                              input bit mp, input logic [31:0] mpt, input logic [3:0] rm,
                              input logic [31:0] ad, input bit fe, input logic [31:0] hpc);
    vec_t v;
    v.pop = pop; v.pt = pt; v.ptt = ptt; v.mp = mp; v.mpt = mpt;
    v.e_rmask = rm; v.e_addr = ad; v.e_fe = fe; v.e_hpc = hpc;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    logic [31:0] r;
    logic [31:0] t1;
    logic [31:0] t2;

    rst        = 1'b1;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    set_in(0, 0, '0, 0, '0);

    // reset, three sequential fetches, then mispredict racing predict_taken+pop
    tbl[0] = mk(0, 0, '0, 0, '0, 4'hF, 32'h1eceb000, 0, 32'hffffffff);
    tbl[1] = mk(0, 0, '0, 0, '0, 4'h0, 32'h1eceb000, 0, 32'hffffffff);
    tbl[2] = mk(0, 0, '0, 0, '0, 4'hF, 32'h1eceb004, 1, 32'h1eceb000);
    tbl[3] = mk(0, 0, '0, 0, '0, 4'h0, 32'h1eceb004, 1, 32'h1eceb000);
    tbl[4] = mk(0, 0, '0, 0, '0, 4'hF, 32'h1eceb008, 1, 32'h1eceb000);
    tbl[5] = mk(0, 0, '0, 0, '0, 4'h0, 32'h1eceb008, 1, 32'h1eceb000);
    tbl[6] = mk(1, 1, 32'h00003000, 1, 32'h00002000, 4'h0, 32'h1eceb00c, 1, 32'h1eceb000);
    tbl[7] = mk(0, 0, '0, 0, '0, 4'hF, 32'h00002000, 0, 32'hffffffff);
    tbl[8] = mk(0, 0, '0, 0, '0, 4'h0, 32'h00002000, 0, 32'hffffffff);
    tbl[9] = mk(0, 0, '0, 0, '0, 4'hF, 32'h00002004, 1, 32'h00002000);

    mem_lat = 1;
    @(posedge clk);
    #1;
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].pop, tbl[i].pt, tbl[i].ptt, tbl[i].mp, tbl[i].mpt);
      settle();
      chk($sformatf("tbl%0d_rmask", i), imem_rmask, tbl[i].e_rmask);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_fetch_en", i), fetch_en, tbl[i].e_fe);
      chk($sformatf("tbl%0d_head_pc", i), fifo_out.pc, tbl[i].e_hpc);
      chk($sformatf("tbl%0d_head_inst", i), fifo_out.inst,
          tbl[i].e_fe ? mem_word(tbl[i].e_hpc) : 32'hffffffff);
      tick();
    end

    // fill to capacity with no pops, then one pop frees a slot
    do_reset(2);
    set_in(0, 0, '0, 0, '0);
    repeat (30) begin settle(); tick(); end
    settle();
    chk("full_rmask", imem_rmask, 4'h0);
    chk("full_fetch_en", fetch_en, 1'b1);
    chk("full_head_pc", fifo_out.pc, RPC);
    set_in(1, 0, '0, 0, '0);
    settle();
    chk("full_pop_rmask", imem_rmask, 4'h0);
    tick();
    set_in(0, 0, '0, 0, '0);
    settle();
    chk("after_pop_rmask", imem_rmask, 4'hF);
    chk("after_pop_addr", imem_addr, 32'h1eceb020);
    tick();
    // response arrives with a pop in the same cycle at count 7
    set_in(1, 0, '0, 0, '0);
    settle();
    chk("pushpop_head_pc", fifo_out.pc, 32'h1eceb004);
    tick();
    for (int k = 0; k < 7; k++) begin
      set_in(1, 0, '0, 0, '0);
      settle();
      chk($sformatf("wrap_order%0d_pc", k), fifo_out.pc, RPC + 32'h8 + 32'(4 * k));
      chk($sformatf("wrap_order%0d_inst", k), fifo_out.inst, mem_word(RPC + 32'h8 + 32'(4 * k)));
      tick();
    end

    // redirect while waiting; stale response two cycles later is dropped
    mem_lat = 2;
    do_reset(2);
    set_in(0, 0, '0, 0, '0);
    settle();
    chk("disc_issue_addr", imem_addr, RPC);
    tick();
    set_in(1, 1, 32'h00001000, 0, '0);
    settle();
    chk("disc_redirect_rmask", imem_rmask, 4'h0);
    tick();
    set_in(0, 0, '0, 0, '0);
    settle();
    chk("disc_stale_rmask", imem_rmask, 4'h0);
    tick();
    settle();
    chk("disc_next_rmask", imem_rmask, 4'hF);
    chk("disc_next_addr", imem_addr, 32'h00001000);
    chk("disc_queue_empty", fetch_en, 1'b0);
    tick();
    repeat (2) begin settle(); tick(); end
    settle();
    chk("disc_head_pc", fifo_out.pc, 32'h00001000);
    chk("disc_head_inst", fifo_out.inst, mem_word(32'h00001000));
    tick();

    // pc wraps modulo 2^32
    mem_lat = 1;
    do_reset(2);
    set_in(0, 0, '0, 1, 32'hfffffffc);
    settle();
    tick();
    set_in(0, 0, '0, 0, '0);
    settle();
    chk("wrap_addr_hi", imem_addr, 32'hfffffffc);
    tick();
    settle();
    tick();
    settle();
    chk("wrap_addr_lo", imem_addr, 32'h00000000);
    chk("wrap_head_pc", fifo_out.pc, 32'hfffffffc);
    tick();

    // randomized traffic against the model
    mem_rand = 1;
    do_reset(2);
    for (int c = 0; c < 4000; c++) begin
      r  = $urandom();
      t1 = $urandom();
      t2 = $urandom();
      if (r[3:0] == 4'hF) t1 = 32'hfffffff0 | t1;
      rst = (r[31:23] == 9'h0);
      set_in(r[7:4] < 4'd11, r[12:8] == 5'd0, {t1[31:2], 2'b00},
             r[19:14] < 6'd2, {t2[31:2], 2'b00});
      settle();
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
